// File: rtl/seg_pkg.sv
// Shared seven-segment definitions.
// Holds the active-low glyph table (dp off), the blank and dash codes, and the
// bcd_to_seg decoder used by bcd_multi_counter and sdDisplay.
// Segment bit order: seg[6:0] = g..a, seg[7] = dp.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    localparam logic [7:0] SEG_GLYPH [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    // Codes 10..15 are not BCD and render as a dash.
    function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
        logic [7:0] glyph;
        glyph = SEG_DASH;
        if (d <= 4'd9) begin
            glyph = SEG_GLYPH[d];
        end
        return glyph;
    endfunction

endpackage

// File: rtl/bcd_decade.sv
// One BCD decade (0..9) with wrap in both directions.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   clr             synchronous clear to 0
//   inc, dec        step up / down (the parent never asserts both)
//   digit           current BCD digit
//   carry_out       combinational, high while digit == 9
//   borrow_out      combinational, high while digit == 0
module bcd_decade (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] digit,
    output logic       carry_out,
    output logic       borrow_out
);

    logic [3:0] digit_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            digit_q <= 4'd0;
        end else if (inc) begin
            digit_q <= (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
        end else if (dec) begin
            digit_q <= (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
        end
    end

    assign digit      = digit_q;
    assign carry_out  = (digit_q == 4'd9);
    assign borrow_out = (digit_q == 4'd0);

endmodule

// File: rtl/bcd_multi_counter.sv
// N-digit BCD up/down counter with a multiplexed seven-segment driver.
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   cnt_up, cnt_dn  single-cycle step pulses (both together: no change)
//   clear           synchronous clear of the count
//   hold            freezes the count; the display keeps scanning
//   count           BCD value, digit k at count[4k+3:4k]
//   limit           one-cycle pulse on up at max or down at zero
//   an              active-low one-hot anodes
//   seg             active-low segments, seg[7] = dp
module bcd_multi_counter
    import seg_pkg::*;
#(
    parameter int unsigned NUMDIGITS = 4,
    parameter int unsigned SCANDIV   = 25000,
    parameter int unsigned SATURATE  = 0,
    parameter int unsigned BLANKLZ   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cnt_up,
    input  logic                   cnt_dn,
    input  logic                   clear,
    input  logic                   hold,
    output logic [4*NUMDIGITS-1:0] count,
    output logic                   limit,
    output logic [NUMDIGITS-1:0]   an,
    output logic [7:0]             seg
);

    localparam int unsigned PW = (SCANDIV > 1) ? $clog2(SCANDIV) : 1;
    localparam int unsigned IW = (NUMDIGITS > 1) ? $clog2(NUMDIGITS) : 1;

    // ---------------- counter ----------------
    logic [NUMDIGITS-1:0] inc, dec, carry, borrow;
    logic [3:0]           digits [NUMDIGITS];
    logic                 up_ok, dn_ok, at_max, at_zero, sat_en;
    logic                 limit_q;

    // Priority: clear > hold > up/down; simultaneous pulses cancel.
    assign up_ok   = cnt_up & ~cnt_dn & ~hold & ~clear;
    assign dn_ok   = cnt_dn & ~cnt_up & ~hold & ~clear;
    assign at_max  = &carry;
    assign at_zero = &borrow;
    assign sat_en  = (SATURATE != 0);

    // Decade k steps only when every lower decade rolls over.
    always_comb begin
        inc    = '0;
        dec    = '0;
        inc[0] = up_ok & ~(sat_en & at_max);
        dec[0] = dn_ok & ~(sat_en & at_zero);
        for (int k = 1; k < int'(NUMDIGITS); k++) begin
            inc[k] = inc[k-1] & carry[k-1];
            dec[k] = dec[k-1] & borrow[k-1];
        end
    end

    for (genvar g = 0; g < int'(NUMDIGITS); g++) begin : gen_decade
        bcd_decade u_decade (
            .clk        (clk),
            .reset      (reset),
            .clr        (clear),
            .inc        (inc[g]),
            .dec        (dec[g]),
            .digit      (digits[g]),
            .carry_out  (carry[g]),
            .borrow_out (borrow[g])
        );
        assign count[4*g +: 4] = digits[g];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            limit_q <= 1'b0;
        end else begin
            limit_q <= (up_ok & at_max) | (dn_ok & at_zero);
        end
    end

    assign limit = limit_q;

    // ---------------- display scan ----------------
    logic [PW-1:0]        presc_q, presc_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [NUMDIGITS-1:0] an_q, an_d;
    logic [7:0]           seg_q, seg_d;
    logic                 tick;
    logic [NUMDIGITS:0]   lz;
    logic [3:0]           sel_digit;
    logic                 sel_blank;

    assign tick = (presc_q == PW'(SCANDIV - 1));

    always_comb begin
        presc_d = tick ? '0 : presc_q + 1'b1;

        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IW'(NUMDIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        // lz[k]: digit k and everything above it are zero.
        lz            = '0;
        lz[NUMDIGITS] = 1'b1;
        for (int k = int'(NUMDIGITS) - 1; k >= 0; k--) begin
            lz[k] = lz[k+1] & borrow[k];
        end

        sel_digit = '0;
        sel_blank = 1'b0;
        for (int k = 0; k < int'(NUMDIGITS); k++) begin
            if (idx_d == IW'(k)) begin
                sel_digit = digits[k];
                sel_blank = (BLANKLZ != 0) && (k > 0) && lz[k];
            end
        end

        // Decode from the new index so an and seg change together.
        seg_d = sel_blank ? SEG_BLANK : bcd_to_seg(sel_digit);
        an_d  = ~(NUMDIGITS'(1) << idx_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= '0;
            an_q    <= ~NUMDIGITS'(1);
            seg_q   <= SEG_GLYPH[0];
        end else begin
            presc_q <= presc_d;
            if (tick) begin
                idx_q <= idx_d;
                an_q  <= an_d;
                seg_q <= seg_d;
            end
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: tb/tb_bcd_multi_counter.sv
// Directed bench: instance a wraps, instance b saturates. Both use
// NUMDIGITS=4, SCANDIV=4 and share reset/clear/hold.
module tb_bcd_multi_counter;

    logic        clk = 1'b0;
    logic        reset, clear, hold;
    logic        up_a, dn_a, up_b, dn_b;
    logic [15:0] count_a, count_b;
    logic        limit_a, limit_b;
    logic [3:0]  an_a, an_b;
    logic [7:0]  seg_a, seg_b;

    int total = 0;
    int bad   = 0;
    // Reference scan position, advanced once per edge.
    int presc_m = 0;
    int idx_m   = 0;

    logic [3:0] an_exp;
    logic [7:0] seg_tab [4];

    always #5 clk = ~clk;

    bcd_multi_counter #(
        .NUMDIGITS (4),
        .SCANDIV   (4),
        .SATURATE  (0),
        .BLANKLZ   (1)
    ) dut_a (
        .clk    (clk),
        .reset  (reset),
        .cnt_up (up_a),
        .cnt_dn (dn_a),
        .clear  (clear),
        .hold   (hold),
        .count  (count_a),
        .limit  (limit_a),
        .an     (an_a),
        .seg    (seg_a)
    );

    bcd_multi_counter #(
        .NUMDIGITS (4),
        .SCANDIV   (4),
        .SATURATE  (1),
        .BLANKLZ   (1)
    ) dut_b (
        .clk    (clk),
        .reset  (reset),
        .cnt_up (up_b),
        .cnt_dn (dn_b),
        .clear  (clear),
        .hold   (hold),
        .count  (count_b),
        .limit  (limit_b),
        .an     (an_b),
        .seg    (seg_b)
    );

    task automatic step();
        @(posedge clk);
        if (reset) begin
            presc_m = 0;
            idx_m   = 0;
        end else if (presc_m == 3) begin
            presc_m = 0;
            idx_m   = (idx_m + 1) % 4;
        end else begin
            presc_m++;
        end
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic ua, input logic da, input logic ub, input logic db);
        up_a = ua;
        dn_a = da;
        up_b = ub;
        dn_b = db;
        step();
        up_a = 1'b0;
        dn_a = 1'b0;
        up_b = 1'b0;
        dn_b = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear = 1'b0;
        hold  = 1'b0;
        up_a  = 1'b0;
        dn_a  = 1'b0;
        up_b  = 1'b0;
        dn_b  = 1'b0;

        // 1. reset held three cycles
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_count", count_a, 16'h0000);
            chk("rst_an", an_a, 4'b1110);
            chk("rst_seg", seg_a, 8'hC0);
            chk("rst_limit", limit_a, 1'b0);
        end
        reset = 1'b0;

        // 4a. saturating down at zero
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        chk("sat_dn_count", count_b, 16'h0000);
        chk("sat_dn_limit", limit_b, 1'b1);
        step();
        chk("sat_dn_limit_drop", limit_b, 1'b0);

        // 2. twelve ups, then watch the scan with blanking
        repeat (12) pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk("up12_count", count_a, 16'h0012);
        chk("up12_limit", limit_a, 1'b0);
        repeat (16) step();
        seg_tab[0] = 8'hA4;
        seg_tab[1] = 8'hF9;
        seg_tab[2] = 8'hFF;
        seg_tab[3] = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            step();
            an_exp = ~(4'b0001 << idx_m);
            chk("scan_an", an_a, an_exp);
            chk("scan_seg", seg_a, seg_tab[idx_m]);
        end

        // clear both
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_count", count_a, 16'h0000);
        chk("clr_limit", limit_a, 1'b0);

        // 3 / 4b. preload 9999, then the upper limit in both modes
        repeat (9999) pulse(1'b1, 1'b0, 1'b1, 1'b0);
        chk("pre_a", count_a, 16'h9999);
        chk("pre_b", count_b, 16'h9999);
        chk("pre_limit", limit_a, 1'b0);
        pulse(1'b1, 1'b0, 1'b1, 1'b0);
        chk("wrap_up_count", count_a, 16'h0000);
        chk("wrap_up_limit", limit_a, 1'b1);
        chk("sat_up_count", count_b, 16'h9999);
        chk("sat_up_limit", limit_b, 1'b1);
        step();
        chk("wrap_up_limit_drop", limit_a, 1'b0);
        chk("sat_up_limit_drop", limit_b, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("wrap_dn_count", count_a, 16'h9999);
        chk("wrap_dn_limit", limit_a, 1'b1);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("dn_borrow_count", count_a, 16'h9998);
        chk("dn_borrow_limit", limit_a, 1'b0);

        // 5. hold, both pulses, clear priority
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (99) pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk("c99_count", count_a, 16'h0099);
        hold = 1'b1;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        hold = 1'b0;
        chk("hold_count", count_a, 16'h0099);
        chk("hold_limit", limit_a, 1'b0);
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        chk("both_count", count_a, 16'h0099);
        chk("both_limit", limit_a, 1'b0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk("carry_count", count_a, 16'h0100);
        clear = 1'b1;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        clear = 1'b0;
        chk("clr_up_count", count_a, 16'h0000);
        chk("clr_up_limit", limit_a, 1'b0);

        // 6. reset mid-scan at index 2 with 0456
        repeat (456) pulse(1'b1, 1'b0, 1'b0, 1'b0);
        chk("c456_count", count_a, 16'h0456);
        for (int i = 0; i < 8 && idx_m != 2; i++) begin
            step();
        end
        chk("mid_idx", an_a, 4'b1011);
        chk("mid_seg", seg_a, 8'h99);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_count", count_a, 16'h0000);
        chk("mid_rst_an", an_a, 4'b1110);
        chk("mid_rst_seg", seg_a, 8'hC0);
        chk("mid_rst_limit", limit_a, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("presc_restart_hold", an_a, 4'b1110);
        end
        step();
        chk("presc_restart_tick", an_a, 4'b1101);
        chk("presc_restart_seg", seg_a, 8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
